// File: rtl/reg_file_sweep.sv
// Parametrised register file: two asynchronous read ports, one synchronous write port,
// optional bypass and hardwired R0, per-register dirty bits and a sequential CLEAR sweep.
module reg_file_sweep #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 0,
    localparam int DEPTH     = 2 ** ADDR_WIDTH
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic signed [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0]        INADDRESS,
    input  logic                         WRITE,
    input  logic [ADDR_WIDTH-1:0]        OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0]        OUT2ADDRESS,
    output logic signed [DATA_WIDTH-1:0] OUT1,
    output logic signed [DATA_WIDTH-1:0] OUT2,
    input  logic                         CLEAR,
    output logic                         BUSY,
    output logic                         WRITE_DROPPED,
    output logic [DEPTH-1:0]             DIRTY
);

    localparam logic BYPASS_EN = (BYPASS != 0);
    localparam logic ZERO_EN   = (ZERO_REG != 0);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [ADDR_WIDTH-1:0]        sweep_cnt;
    logic signed [DATA_WIDTH-1:0] regs [DEPTH];
    logic                         write_ok;

    assign BUSY     = (state == SWEEP);
    assign write_ok = WRITE && !BUSY && !(ZERO_EN && (INADDRESS == '0));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (CLEAR) state_nxt = SWEEP;
            SWEEP:   if (sweep_cnt == LAST_ADDR) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Writes and sweep steps never overlap: a legal write requires the sweep to be idle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            DIRTY         <= '0;
            sweep_cnt     <= '0;
            WRITE_DROPPED <= 1'b0;
        end else begin
            WRITE_DROPPED <= WRITE && BUSY;
            if (write_ok) begin
                regs[INADDRESS]  <= IN;
                DIRTY[INADDRESS] <= 1'b1;
            end
            if (state == SWEEP) begin
                regs[sweep_cnt]  <= '0;
                DIRTY[sweep_cnt] <= 1'b0;
                sweep_cnt        <= sweep_cnt + 1'b1;
            end else if (CLEAR) begin
                sweep_cnt <= '0;
            end
        end
    end

    // Read priority: hardwired zero, then same-cycle forwarding, then storage.
    always_comb begin
        OUT1 = regs[OUT1ADDRESS];
        if (ZERO_EN && (OUT1ADDRESS == '0)) begin
            OUT1 = '0;
        end else if (BYPASS_EN && write_ok && (OUT1ADDRESS == INADDRESS)) begin
            OUT1 = IN;
        end
    end

    always_comb begin
        OUT2 = regs[OUT2ADDRESS];
        if (ZERO_EN && (OUT2ADDRESS == '0)) begin
            OUT2 = '0;
        end else if (BYPASS_EN && write_ok && (OUT2ADDRESS == INADDRESS)) begin
            OUT2 = IN;
        end
    end

endmodule

// File: tb/tb_reg_file_sweep.sv
// Bench for reg_file_sweep: randomized and directed traffic on a default instance checked
// against a behavioural model, plus directed checks on no-bypass/zero-R0 and 16x16 instances.
module tb_reg_file_sweep;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (8 bit, 8 deep, bypass on, no zero register)
    logic [7:0] a_in;
    logic [2:0] a_inaddr, a_r1, a_r2;
    logic       a_write, a_clear;
    logic [7:0] a_out1, a_out2, a_dirty;
    logic       a_busy, a_drop;

    reg_file_sweep dut_a (
        .CLK(clk), .RESET(rst), .IN(a_in), .INADDRESS(a_inaddr), .WRITE(a_write),
        .OUT1ADDRESS(a_r1), .OUT2ADDRESS(a_r2), .OUT1(a_out1), .OUT2(a_out2),
        .CLEAR(a_clear), .BUSY(a_busy), .WRITE_DROPPED(a_drop), .DIRTY(a_dirty)
    );

    // Instance B: bypass off, hardwired-zero R0
    logic [7:0] b_in;
    logic [2:0] b_inaddr, b_r1, b_r2;
    logic       b_write, b_clear;
    logic [7:0] b_out1, b_out2, b_dirty;
    logic       b_busy, b_drop;

    reg_file_sweep #(.BYPASS(0), .ZERO_REG(1)) dut_b (
        .CLK(clk), .RESET(rst), .IN(b_in), .INADDRESS(b_inaddr), .WRITE(b_write),
        .OUT1ADDRESS(b_r1), .OUT2ADDRESS(b_r2), .OUT1(b_out1), .OUT2(b_out2),
        .CLEAR(b_clear), .BUSY(b_busy), .WRITE_DROPPED(b_drop), .DIRTY(b_dirty)
    );

    // Instance C: 16-bit data, 16 registers
    logic [15:0] c_in;
    logic [3:0]  c_inaddr, c_r1, c_r2;
    logic        c_write, c_clear;
    logic [15:0] c_out1, c_out2, c_dirty;
    logic        c_busy, c_drop;

    reg_file_sweep #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut_c (
        .CLK(clk), .RESET(rst), .IN(c_in), .INADDRESS(c_inaddr), .WRITE(c_write),
        .OUT1ADDRESS(c_r1), .OUT2ADDRESS(c_r2), .OUT1(c_out1), .OUT2(c_out2),
        .CLEAR(c_clear), .BUSY(c_busy), .WRITE_DROPPED(c_drop), .DIRTY(c_dirty)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model of instance A: contents, dirty flags, remaining sweep steps.
    logic [7:0] m_mem [8];
    logic [7:0] m_dirty;
    int         m_left;
    int         m_idx;
    logic       m_drop;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
        m_dirty = 8'h00;
        m_left  = 0;
        m_idx   = 0;
        m_drop  = 1'b0;
    endtask

    function automatic logic [7:0] model_read(input logic [2:0] ra);
        if (a_write && (m_left == 0) && (ra == a_inaddr)) return a_in;
        return m_mem[ra];
    endfunction

    task automatic model_edge();
        bit busy;
        busy   = (m_left > 0);
        m_drop = a_write && busy;
        if (a_write && !busy) begin
            m_mem[a_inaddr]   = a_in;
            m_dirty[a_inaddr] = 1'b1;
        end
        if (busy) begin
            m_mem[m_idx]   = 8'h00;
            m_dirty[m_idx] = 1'b0;
            m_idx++;
            m_left--;
        end else if (a_clear) begin
            m_left = 8;
            m_idx  = 0;
        end
    endtask

    // One cycle on A: called 1 ns after a posedge, returns 1 ns after the next one.
    task automatic cycle_a(input logic w, input logic [2:0] wa, input logic [7:0] wd,
                           input logic clr, input logic [2:0] r1, input logic [2:0] r2);
        a_write = w; a_inaddr = wa; a_in = wd; a_clear = clr; a_r1 = r1; a_r2 = r2;
        exp_q.push_back(model_read(r1));
        exp_q.push_back(model_read(r2));
        #2;
        chk("a_out1", a_out1, exp_q.pop_front());
        chk("a_out2", a_out2, exp_q.pop_front());
        chk("a_busy", a_busy, m_left > 0);
        chk("a_dirty", a_dirty, m_dirty);
        chk("a_drop", a_drop, m_drop);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_a(input logic [2:0] r1);
        cycle_a(1'b0, 3'd0, 8'h00, 1'b0, r1, r1);
    endtask

    // Asserts reset mid-cycle and checks every output settles without a clock edge.
    task automatic reset_mid(input string tag);
        a_write = 1'b0; a_clear = 1'b0;
        b_write = 1'b0; b_clear = 1'b0;
        c_write = 1'b0; c_clear = 1'b0;
        #2 rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_r1 = 3'(i); a_r2 = 3'(7 - i);
            #1;
            chk({tag, "_out1"}, a_out1, 0);
            chk({tag, "_out2"}, a_out2, 0);
        end
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_dirty"}, a_dirty, 0);
        chk({tag, "_drop"}, a_drop, 0);
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a();
        for (int i = 0; i < 8; i++) cycle_a(1'b1, 3'(i), 8'(i + 1), 1'b0, 3'(i), 3'(i));
    endtask

    int busy_cnt;

    initial begin
        a_write = 0; a_clear = 0; a_in = 0; a_inaddr = 0; a_r1 = 0; a_r2 = 0;
        b_write = 0; b_clear = 0; b_in = 0; b_inaddr = 0; b_r1 = 0; b_r2 = 0;
        c_write = 0; c_clear = 0; c_in = 0; c_inaddr = 0; c_r1 = 0; c_r2 = 0;
        model_reset();
        @(posedge clk);
        #1;
        reset_mid("reset");

        // Bypass: 95 to R2 visible before and after the edge
        cycle_a(1'b1, 3'd2, 8'd95, 1'b0, 3'd2, 3'd0);
        chk("r2_after", a_out1, 95);
        chk("r2_dirty", a_dirty, 8'b0000_0100);
        cycle_a(1'b1, 3'd7, 8'hFF, 1'b0, 3'd7, 3'd7);
        chk("r7_p1", a_out1, 8'hFF);
        chk("r7_p2", a_out2, 8'hFF);

        // Full sweep: R3 holds 4 until the 4th sweep edge
        load_a();
        cycle_a(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd3);
        busy_cnt = 0;
        while (a_busy && busy_cnt < 40) begin
            chk("sweep_r3", a_out1, (busy_cnt >= 4) ? 0 : 4);
            idle_a(3'd3);
            busy_cnt++;
        end
        chk("busy_len", busy_cnt, 8);
        chk("swept_dirty", a_dirty, 0);
        for (int i = 0; i < 8; i++) idle_a(3'(i));

        // Dropped write and ignored CLEAR during a sweep
        load_a();
        cycle_a(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd4);
        busy_cnt = 0;
        while (a_busy && busy_cnt < 40) begin
            if (busy_cnt == 2) begin
                cycle_a(1'b1, 3'd4, 8'd15, 1'b0, 3'd4, 3'd4);
                chk("drop_pulse", a_drop, 1);
                chk("r4_kept", a_out1, 5);
            end else if (busy_cnt == 5) begin
                cycle_a(1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 3'd4);
            end else begin
                idle_a(3'd4);
            end
            busy_cnt++;
        end
        chk("busy_len_reclear", busy_cnt, 8);
        idle_a(3'd4);

        // Reset at sweep cycle 3
        load_a();
        cycle_a(1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 3'd6);
        idle_a(3'd7);
        idle_a(3'd7);
        reset_mid("reset_sweep");
        for (int i = 0; i < 4; i++) idle_a(3'(i + 4));

        // Randomized traffic with occasional CLEAR and mid-cycle reset
        for (int n = 0; n < 400; n++) begin
            logic [2:0] wa, r1;
            wa = 3'($urandom_range(0, 7));
            r1 = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 79) == 0) begin
                reset_mid("reset_rand");
            end else begin
                cycle_a(1'($urandom_range(0, 1)), wa, 8'($urandom),
                        $urandom_range(0, 15) == 0, r1, 3'($urandom_range(0, 7)));
            end
        end
        reset_mid("reset_end");

        // Instance B: no bypass, zero register
        b_write = 1; b_inaddr = 3'd1; b_in = 8'd28; b_r1 = 3'd1; b_r2 = 3'd1;
        #2;
        chk("b_old_value", b_out1, 0);
        @(posedge clk);
        #1;
        chk("b_new_value", b_out1, 28);
        b_inaddr = 3'd0; b_in = 8'd50; b_r1 = 3'd0; b_r2 = 3'd0;
        #2;
        chk("b_r0_before", b_out1, 0);
        @(posedge clk);
        #1;
        b_write = 0; b_r2 = 3'd1;
        #1;
        chk("b_r0_after", b_out1, 0);
        chk("b_r1_kept", b_out2, 28);
        chk("b_dirty", b_dirty, 8'b0000_0010);
        chk("b_no_drop", b_drop, 0);

        // Instance C: 16-bit, 16-deep
        @(posedge clk);
        #1;
        c_write = 1; c_inaddr = 4'd15; c_in = 16'h8001; c_r1 = 4'd15; c_r2 = 4'd15;
        #2;
        chk("c_bypass", c_out1, 16'h8001);
        @(posedge clk);
        #1;
        c_write = 0;
        #1;
        chk("c_r15", c_out2, 16'h8001);
        chk("c_dirty", c_dirty, 16'h8000);
        c_clear = 1;
        @(posedge clk);
        #1;
        c_clear = 0;
        busy_cnt = 0;
        while (c_busy && busy_cnt < 60) begin
            @(posedge clk);
            #1;
            busy_cnt++;
        end
        chk("c_busy_len", busy_cnt, 16);
        chk("c_r15_swept", c_out1, 0);
        chk("c_dirty_swept", c_dirty, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
